spi_slave: RTL and testbench

Synchronous SPI slave: the far end of the link driven by `spi_master`. It oversamples `spi_clk`, `spi_ss` and `spi_mosi` in the system clock domain and shifts received words out on `dout`/`dout_valid`. It fetches transmit words from an external FIFO and shifts them onto `spi_miso`. CPOL/CPHA are programmed through the same register-port style as the master; the block serves as DUT for slave-side benches and as the bus-functional partner for master benches.

---
 rtl/spi_slave_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_slave.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave: FSM states and the mode register layout.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int REG_MODE_ADDR = 0;
    localparam int CPHA_BIT      = 0;
    localparam int CPOL_BIT      = 1;

    // The leading edge leaves the idle level: rising when CPOL=0, falling when CPOL=1.
    function automatic logic leading_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus registered rise/fall pulses
// (pin edge appears on rise/fall three clk cycles later).
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;
    logic rise_reg;
    logic fall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
            rise_reg <= sync_reg & ~prev_reg;
            fall_reg <= ~sync_reg & prev_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI slave oversampling spi_clk/spi_ss/spi_mosi in the clk domain; receives words on
// dout/dout_valid and transmits words fetched from an external FIFO on spi_miso.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int data_width_g     = 8,
    parameter int reg_width_g      = 8,
    parameter int reg_addr_width_g = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        spi_clk,
    input  logic                        spi_ss,
    input  logic                        spi_mosi,
    output logic                        spi_miso,
    output logic                        fifo_req_data,
    input  logic [data_width_g-1:0]     fifo_din,
    input  logic                        fifo_din_valid,
    input  logic                        fifo_empty,
    input  logic [reg_addr_width_g-1:0] reg_addr,
    input  logic [reg_width_g-1:0]      reg_din,
    input  logic                        reg_din_val,
    output logic                        reg_ack,
    output logic                        reg_err,
    output logic                        busy,
    output logic [data_width_g-1:0]     dout,
    output logic                        dout_valid
);

    localparam int CNT_W = (data_width_g > 2) ? $clog2(data_width_g) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(data_width_g - 1);

    // Index 0 carries spi_clk, index 1 carries spi_ss.
    logic [1:0] pin_vec;
    logic [1:0] rise_vec;
    logic [1:0] fall_vec;

    assign pin_vec = {spi_ss, spi_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            spi_sync_edge u_sync (
                .clk  (clk),
                .rst  (rst),
                .din  (pin_vec[gi]),
                .rise (rise_vec[gi]),
                .fall (fall_vec[gi])
            );
        end
    endgenerate

    logic mosi_meta_reg;
    logic mosi_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
        end else begin
            mosi_meta_reg <= spi_mosi;
            mosi_sync_reg <= mosi_meta_reg;
        end
    end

    state_t                  state_reg;
    logic                    cpol_reg;
    logic                    cpha_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic [data_width_g-1:0] rx_shift_reg;
    logic [data_width_g-1:0] tx_shift_reg;
    logic                    fetch_pending_reg;
    logic                    miso_reg;
    logic                    req_reg;
    logic                    ack_reg;
    logic                    err_reg;
    logic                    busy_reg;
    logic [data_width_g-1:0] dout_reg;
    logic                    dout_valid_reg;

    logic ss_rise;
    logic ss_fall;
    logic lead;
    logic trail;
    logic sample_edge;
    logic shift_edge;
    logic mode_write_ok;
    logic [data_width_g-1:0] load_word;
    logic [data_width_g-1:0] rx_word;
    logic unused_reg_bits;

    assign ss_rise     = rise_vec[1];
    assign ss_fall     = fall_vec[1];
    assign lead        = leading_edge(cpol_reg, rise_vec[0], fall_vec[0]);
    assign trail       = leading_edge(~cpol_reg, rise_vec[0], fall_vec[0]);
    assign sample_edge = cpha_reg ? trail : lead;
    assign shift_edge  = cpha_reg ? lead : trail;
    assign load_word   = fetch_pending_reg ? fifo_din : '0;
    assign rx_word     = {rx_shift_reg[data_width_g-2:0], mosi_sync_reg};

    assign mode_write_ok = (reg_addr == reg_addr_width_g'(REG_MODE_ADDR)) && (state_reg == ST_IDLE);
    assign unused_reg_bits = ^reg_din[reg_width_g-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            cpol_reg          <= 1'b0;
            cpha_reg          <= 1'b0;
            bit_cnt_reg       <= '0;
            rx_shift_reg      <= '0;
            tx_shift_reg      <= '0;
            fetch_pending_reg <= 1'b0;
            miso_reg          <= 1'b0;
            req_reg           <= 1'b0;
            ack_reg           <= 1'b0;
            err_reg           <= 1'b0;
            busy_reg          <= 1'b0;
            dout_reg          <= '0;
            dout_valid_reg    <= 1'b0;
        end else begin
            req_reg        <= 1'b0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
            dout_valid_reg <= 1'b0;

            if (reg_din_val) begin
                if (mode_write_ok) begin
                    ack_reg  <= 1'b1;
                    cpol_reg <= reg_din[CPOL_BIT];
                    cpha_reg <= reg_din[CPHA_BIT];
                end else begin
                    err_reg <= 1'b1;
                end
            end

            // Deselect wins over everything, including a coincident final sample.
            if (ss_rise) begin
                state_reg         <= ST_IDLE;
                busy_reg          <= 1'b0;
                miso_reg          <= 1'b0;
                bit_cnt_reg       <= '0;
                fetch_pending_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (ss_fall) begin
                            state_reg         <= ST_LOAD;
                            busy_reg          <= 1'b1;
                            bit_cnt_reg       <= '0;
                            req_reg           <= ~fifo_empty;
                            fetch_pending_reg <= ~fifo_empty;
                        end
                    end
                    ST_LOAD: begin
                        if (!fetch_pending_reg || fifo_din_valid) begin
                            state_reg         <= ST_SHIFT;
                            fetch_pending_reg <= 1'b0;
                            // CPHA=0 must present the MSB before the first (sampling) edge.
                            if (!cpha_reg) begin
                                miso_reg     <= load_word[data_width_g-1];
                                tx_shift_reg <= {load_word[data_width_g-2:0], 1'b0};
                            end else begin
                                tx_shift_reg <= load_word;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (fetch_pending_reg && fifo_din_valid) begin
                            tx_shift_reg      <= fifo_din;
                            fetch_pending_reg <= 1'b0;
                        end
                        if (shift_edge) begin
                            miso_reg     <= tx_shift_reg[data_width_g-1];
                            tx_shift_reg <= {tx_shift_reg[data_width_g-2:0], 1'b0};
                        end
                        if (sample_edge) begin
                            rx_shift_reg <= rx_word;
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg    <= '0;
                                dout_reg       <= rx_word;
                                dout_valid_reg <= 1'b1;
                                // Burst: fetch the next word now; it lands before the next shift edge.
                                if (!fifo_empty) begin
                                    req_reg           <= 1'b1;
                                    fetch_pending_reg <= 1'b1;
                                end else begin
                                    tx_shift_reg <= '0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_miso      = miso_reg;
    assign fifo_req_data = req_reg;
    assign reg_ack       = ack_reg;
    assign reg_err       = err_reg;
    assign busy          = busy_reg;
    assign dout          = dout_reg;
    assign dout_valid    = dout_valid_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master and FIFO drive the slave; a scoreboard
// queue of expected received words is checked by a monitor on every dout_valid.
module tb_spi_slave;

    localparam int HALF  = 6;
    localparam int SETUP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_ss = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       fifo_req_data;
    logic [7:0] fifo_din = '0;
    logic       fifo_din_valid = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] reg_addr = '0;
    logic [7:0] reg_din = '0;
    logic       reg_din_val = 1'b0;
    logic       reg_ack;
    logic       reg_err;
    logic       busy;
    logic [7:0] dout;
    logic       dout_valid;

    spi_slave #(
        .data_width_g     (8),
        .reg_width_g      (8),
        .reg_addr_width_g (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_clk        (spi_clk),
        .spi_ss         (spi_ss),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .fifo_req_data  (fifo_req_data),
        .fifo_din       (fifo_din),
        .fifo_din_valid (fifo_din_valid),
        .fifo_empty     (fifo_empty),
        .reg_addr       (reg_addr),
        .reg_din        (reg_din),
        .reg_din_val    (reg_din_val),
        .reg_ack        (reg_ack),
        .reg_err        (reg_err),
        .busy           (busy),
        .dout           (dout),
        .dout_valid     (dout_valid)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         req_count = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_dout[$];
    logic [7:0] exp_miso[$];
    logic [7:0] m_words[8];
    logic [7:0] f_words[8];
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, spi_miso, 0);
        check({tag, "_req"}, fifo_req_data, 0);
        check({tag, "_ack"}, reg_ack, 0);
        check({tag, "_err"}, reg_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_dout"}, dout, 0);
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] data, input logic exp_ack);
        @(negedge clk);
        reg_addr    = addr;
        reg_din     = data;
        reg_din_val = 1'b1;
        @(negedge clk);
        reg_din_val = 1'b0;
        check("reg_ack", reg_ack, exp_ack);
        check("reg_err", reg_err, !exp_ack);
        if (exp_ack) begin
            m_cpol = data[1];
            m_cpha = data[0];
        end
    endtask

    // Behavioural master: MSB first, samples/shifts on the edges the current mode dictates.
    task automatic master_xfer(input int nwords, input int stop_bits, input bit do_reset, input bit mid_reg);
        logic [7:0] rx;
        int         bits = 0;
        int         done_words = 0;
        bit         stopped = 0;
        @(negedge clk);
        spi_ss = 1'b0;
        if (!m_cpha) spi_mosi = m_words[0][7];
        repeat (SETUP) @(negedge clk);
        if (mid_reg) begin
            check("busy_mid", busy, 1);
            reg_write(8'h00, 8'h03, 1'b0);
        end
        for (int w = 0; w < nwords && !stopped; w++) begin
            rx = '0;
            for (int b = 7; b >= 0 && !stopped; b--) begin
                spi_clk = ~m_cpol;
                if (!m_cpha) rx = {rx[6:0], spi_miso};
                else spi_mosi = m_words[w][b];
                repeat (HALF) @(negedge clk);
                spi_clk = m_cpol;
                if (m_cpha) rx = {rx[6:0], spi_miso};
                else if (b > 0) spi_mosi = m_words[w][b-1];
                else if (w + 1 < nwords) spi_mosi = m_words[w+1][7];
                else spi_mosi = 1'b0;
                repeat (HALF) @(negedge clk);
                bits++;
                if (stop_bits != 0 && bits == stop_bits) stopped = 1;
            end
            if (!stopped) begin
                check("miso_word", rx, exp_miso.pop_front());
                done_words++;
            end
        end
        if (do_reset) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs("rst_mid");
            rst    = 1'b0;
            m_cpol = 1'b0;
            m_cpha = 1'b0;
            spi_clk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = done_words; i < nwords; i++) void'(exp_dout.pop_back());
        exp_miso.delete();
    endtask

    task automatic run_xfer(input int nwords, input int fcount, input int stop_bits,
                            input bit do_reset, input bit mid_reg);
        int req0;
        fq.delete();
        exp_miso.delete();
        for (int i = 0; i < fcount; i++) fq.push_back(f_words[i]);
        fifo_empty = (fcount == 0);
        for (int w = 0; w < nwords; w++) begin
            exp_dout.push_back(m_words[w]);
            exp_miso.push_back((w < fcount) ? f_words[w] : 8'h00);
        end
        spi_clk = m_cpol;
        repeat (4) @(negedge clk);
        req0 = req_count;
        master_xfer(nwords, stop_bits, do_reset, mid_reg);
        if (stop_bits == 0) check("fifo_reqs", req_count - req0, fcount);
        check("busy_after", busy, 0);
        check("miso_after", spi_miso, 0);
        check("dout_pending", exp_dout.size(), 0);
    endtask

    initial begin
        logic [7:0] rnd;
        int         n;
        int         fc;

        fork
            // FIFO model: answers a request with the next word one cycle later.
            forever begin
                @(posedge clk);
                fifo_din_valid <= 1'b0;
                if (fifo_req_data === 1'b1) begin
                    req_count++;
                    if (fq.size() > 0) begin
                        fifo_din <= fq.pop_front();
                    end else begin
                        fifo_din <= '0;
                        check("req_while_empty", 1, 0);
                    end
                    fifo_din_valid <= 1'b1;
                    fifo_empty     <= (fq.size() == 0);
                end
            end
            // Scoreboard monitor.
            forever begin
                @(negedge clk);
                if (dout_valid === 1'b1) begin
                    if (exp_dout.size() == 0) check("dout_unexpected", 1, 0);
                    else check("dout", dout, exp_dout.pop_front());
                end
                if (reg_ack === 1'b1 || reg_err === 1'b1) check("ack_err_excl", reg_ack & reg_err, 0);
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Mode 0 out of reset, single word.
        m_words[0] = 8'hA5; f_words[0] = 8'h3C;
        run_xfer(1, 1, 0, 0, 0);

        // Mode 3 burst.
        reg_write(8'h00, 8'h03, 1'b1);
        m_words[0] = 8'h01; m_words[1] = 8'h80; m_words[2] = 8'hFF;
        f_words[0] = 8'h11; f_words[1] = 8'h22; f_words[2] = 8'h33;
        run_xfer(3, 3, 0, 0, 0);

        // Empty FIFO, mode 1.
        reg_write(8'h00, 8'h01, 1'b1);
        m_words[0] = 8'h5A;
        run_xfer(1, 0, 0, 0, 0);

        // Abort after 5 bits, then a clean transfer.
        reg_write(8'h00, 8'h00, 1'b1);
        m_words[0] = 8'hE7; f_words[0] = 8'h77;
        run_xfer(1, 1, 5, 0, 0);
        m_words[0] = 8'hC3; f_words[0] = 8'h96;
        run_xfer(1, 1, 0, 0, 0);

        // Register errors; the busy write must leave mode 0 in force.
        reg_write(8'h01, 8'h03, 1'b0);
        m_words[0] = 8'h4B; f_words[0] = 8'hD2;
        run_xfer(1, 1, 0, 0, 1);
        reg_write(8'h00, 8'h02, 1'b1);
        m_words[0] = 8'h6E; f_words[0] = 8'h19;
        run_xfer(1, 1, 0, 0, 0);
        reg_write(8'h00, 8'hFD, 1'b1);
        m_words[0] = 8'h2D; f_words[0] = 8'hB4;
        run_xfer(1, 1, 0, 0, 0);

        // Reset mid-transfer from mode 3; the following transfer runs in mode 0.
        reg_write(8'h00, 8'h03, 1'b1);
        m_words[0] = 8'h99; f_words[0] = 8'h42;
        run_xfer(1, 1, 3, 1, 0);
        m_words[0] = 8'h3E; f_words[0] = 8'hC1;
        run_xfer(1, 1, 0, 0, 0);

        // Randomised transfers.
        for (int t = 0; t < 8; t++) begin
            rnd = 8'($urandom);
            reg_write(8'h00, rnd, 1'b1);
            n  = $urandom_range(1, 3);
            fc = $urandom_range(0, n);
            for (int i = 0; i < n; i++) begin
                m_words[i] = 8'($urandom);
                f_words[i] = 8'($urandom);
            end
            run_xfer(n, fc, 0, 0, 0);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
